// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared constants, FSM encodings and parity helper for the PS/2 keyboard controller.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_PRESENT,
    HS_RELEASE
  } hs_state_t;

  // True when data plus parity carries an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return (^data) ^ parity;
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Keyboard port seen by the I/O bus: 4-phase KBDready/KBDread handshake plus the byte.
interface ps2_kbd_ctrl_if;
  logic       KBDready;
  logic [7:0] scancode;
  logic       KBDread;

  modport slave  (input KBDread, output KBDready, output scancode);
  modport master (output KBDread, input KBDready, input scancode);
endinterface

// File: rtl/ps2_kbd_ctrl_fifo.sv
// Synchronous scancode FIFO; a push when full and a pop when empty are ignored.
module kbd_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [7:0]                     din,
  output logic [7:0]                     head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(FIFO_DEPTH):0]    count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          wr, rd;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: deserialises device frames, buffers good bytes and hands
// them to the I/O bus one at a time over a 4-phase ready/read handshake.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  ps2_kbd_ctrl_if.slave        bus,
  output logic                 overflow,
  output logic                 frame_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2, fall;
  rx_state_t     rx_state, rx_next;
  hs_state_t     hs_state, hs_next;
  logic [3:0]    bitcnt;
  logic [8:0]    shreg;
  logic [9:0]    frame_bits;
  logic [TW-1:0] tmr;
  logic          frame_done, frame_good, abort;
  logic          push, pop, latch;
  logic [7:0]    push_data, fifo_head, scancode_q;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  // Idle-high reset value keeps a reset from looking like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      {clk_s1, clk_s2, clk_prev} <= 3'b111;
      {data_s1, data_s2}         <= 2'b11;
    end else begin
      {clk_s1, clk_s2, clk_prev} <= {ps2_clk, clk_s1, clk_s2};
      {data_s1, data_s2}         <= {ps2_data, data_s1};
    end
  end

  assign fall       = clk_prev && !clk_s2;
  assign frame_bits = {data_s2, shreg};
  assign frame_good = odd_parity_ok(frame_bits[7:0], frame_bits[8]) && frame_bits[9];

  always_comb begin
    rx_next    = rx_state;
    frame_done = 1'b0;
    abort      = 1'b0;
    case (rx_state)
      RX_IDLE:  if (fall && !data_s2) rx_next = RX_SHIFT;
      RX_SHIFT: begin
        if (fall) begin
          if (bitcnt == 4'(FRAME_BITS - 1)) begin
            rx_next    = RX_IDLE;
            frame_done = 1'b1;
          end
        end else if (tmr == '0) begin
          rx_next = RX_IDLE;
          abort   = 1'b1;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state  <= RX_IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      tmr       <= '0;
      push      <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rx_state  <= rx_next;
      push      <= frame_done && frame_good;
      push_data <= frame_bits[7:0];
      frame_err <= (frame_done && !frame_good) || abort;
      if (push && fifo_full) overflow <= 1'b1;
      // Inactivity timer restarts on every PS/2 edge and only runs mid-frame.
      if (fall) tmr <= TW'(TIMEOUT);
      else if (rx_state == RX_SHIFT && tmr != '0) tmr <= tmr - 1'b1;
      if (rx_state == RX_IDLE && rx_next == RX_SHIFT) begin
        bitcnt <= 4'd1;
      end else if (rx_state == RX_SHIFT && fall) begin
        bitcnt <= bitcnt + 1'b1;
        shreg  <= frame_bits[9:1];
      end
    end
  end

  kbd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    hs_next = hs_state;
    pop     = 1'b0;
    latch   = 1'b0;
    case (hs_state)
      HS_IDLE: if (!fifo_empty) begin
        latch   = 1'b1;
        hs_next = HS_PRESENT;
      end
      HS_PRESENT: if (bus.KBDread && fifo_count != '0) begin
        pop     = 1'b1;
        hs_next = HS_RELEASE;
      end
      HS_RELEASE: if (!bus.KBDread) hs_next = HS_IDLE;
      default:    hs_next = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_state   <= HS_IDLE;
      scancode_q <= '0;
    end else begin
      hs_state <= hs_next;
      if (latch) scancode_q <= fifo_head;
    end
  end

  assign bus.KBDready = (hs_state == HS_PRESENT);
  assign bus.scancode = scancode_q;
endmodule
